mem_port_arbiter: RTL and testbench

//  Shares the single-port byte-addressable Memory unit (comb read, posedge write) between
//  the instruction-fetch port (I, read-only) and the data port (D, read/write).

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and Memory-side signals shared by the arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 12
);
    logic                    i_req;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic                    i_ack;
    logic [8*BYTE_SIZE-1:0]  i_rdata;
    logic                    i_err;

    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [8*BYTE_SIZE-1:0]  d_wdata;
    logic                    d_ack;
    logic [8*BYTE_SIZE-1:0]  d_rdata;
    logic                    d_err;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [8*BYTE_SIZE-1:0]  mem_wd;
    logic [8*BYTE_SIZE-1:0]  mem_rd;

    logic                    busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        output mem_we, mem_addr, mem_wd, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        input  mem_we, mem_addr, mem_wd, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port byte memory between the fetch (read-only) and data ports.
// One access in flight: IDLE -> ACCESS -> DONE, with a one-cycle ack per request.
module mem_port_arbiter #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_DEPTH  = 20,
    parameter bit RR_MODE    = 1'b1
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int DW = 8 * BYTE_SIZE;
    localparam logic [ADDR_WIDTH:0] LAST_OFS  = (ADDR_WIDTH + 1)'(BYTE_SIZE - 1);
    localparam logic [ADDR_WIDTH:0] LAST_BYTE = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t          r_state;
    logic            r_ownerD;
    logic            r_lastD;
    logic            r_iAck;
    logic            r_iErr;
    logic [DW-1:0]   r_iRdata;
    logic            r_dAck;
    logic            r_dErr;
    logic [DW-1:0]   r_dRdata;

    logic                  w_access;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH:0]   w_endAddr;
    logic                  w_oor;
    logic                  w_grantD;

    assign w_access  = (r_state == ACCESS);
    assign w_addr    = r_ownerD ? bus.d_addr : bus.i_addr;
    // One extra bit so an access running past the top of the address space cannot wrap to a legal address.
    assign w_endAddr = {1'b0, w_addr} + LAST_OFS;
    assign w_oor     = (w_endAddr > LAST_BYTE);

    // On contention D wins unless round-robin says D had the previous grant.
    assign w_grantD  = bus.d_req & (~bus.i_req | ~RR_MODE | ~r_lastD);

    // Memory strobes are combinational from state so a reset mid-access kills the write at once.
    assign bus.mem_we   = w_access & r_ownerD & bus.d_we & ~w_oor;
    assign bus.mem_addr = w_access ? w_addr : '0;
    assign bus.mem_wd   = (w_access & r_ownerD) ? bus.d_wdata : '0;
    assign bus.busy     = (r_state != IDLE);

    assign bus.i_ack   = r_iAck;
    assign bus.i_err   = r_iErr;
    assign bus.i_rdata = r_iRdata;
    assign bus.d_ack   = r_dAck;
    assign bus.d_err   = r_dErr;
    assign bus.d_rdata = r_dRdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ownerD <= 1'b1;
            r_lastD  <= 1'b0;
            r_iAck   <= 1'b0;
            r_iErr   <= 1'b0;
            r_iRdata <= '0;
            r_dAck   <= 1'b0;
            r_dErr   <= 1'b0;
            r_dRdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_req | bus.d_req) begin
                        r_ownerD <= w_grantD;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_ownerD) begin
                        r_dAck <= 1'b1;
                        r_dErr <= w_oor;
                        if (!bus.d_we) begin
                            r_dRdata <= w_oor ? '0 : bus.mem_rd;
                        end
                    end else begin
                        r_iAck   <= 1'b1;
                        r_iErr   <= w_oor;
                        r_iRdata <= w_oor ? '0 : bus.mem_rd;
                    end
                    r_lastD <= r_ownerD;
                    r_state <= DONE;
                end
                DONE: begin
                    r_iAck  <= 1'b0;
                    r_iErr  <= 1'b0;
                    r_dAck  <= 1'b0;
                    r_dErr  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance, each with its own
// byte memory; acks are scored against an in-order queue of expected completions.
module tb_mem_port_arbiter;
    localparam int BS    = 4;
    localparam int AW    = 12;
    localparam int DEPTH = 20;

    typedef struct {
        logic        isD;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic        isD;
        logic [31:0] rdata;
        logic        err;
    } ackExp_t;

    logic clk;
    logic reset;
    logic memLoad;

    int total;
    int bad;
    int ackRR;
    int ackFP;
    int weRR;
    int weFP;

    ackExp_t qRR[$];
    ackExp_t qFP[$];

    logic [7:0] memRR [0:DEPTH-1];
    logic [7:0] memFP [0:DEPTH-1];

    vec_t vecs[14];

    mem_port_arbiter_if #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW)) busRR ();
    mem_port_arbiter_if #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW)) busFP ();

    mem_port_arbiter #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RR_MODE(1'b1)) dutRR (
        .clk   (clk),
        .reset (reset),
        .bus   (busRR.slave)
    );

    mem_port_arbiter #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RR_MODE(1'b0)) dutFP (
        .clk   (clk),
        .reset (reset),
        .bus   (busFP.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: combinational little-endian read, posedge write, bytes past DEPTH read as zero.
    always @(posedge clk) begin
        if (memLoad) begin
            for (int k = 0; k < DEPTH; k++) memRR[k] <= 8'(k + 1);
        end else if (busRR.mem_we) begin
            for (int b = 0; b < BS; b++)
                if (int'(busRR.mem_addr) + b < DEPTH) memRR[int'(busRR.mem_addr) + b] <= busRR.mem_wd[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (memLoad) begin
            for (int k = 0; k < DEPTH; k++) memFP[k] <= 8'(k + 1);
        end else if (busFP.mem_we) begin
            for (int b = 0; b < BS; b++)
                if (int'(busFP.mem_addr) + b < DEPTH) memFP[int'(busFP.mem_addr) + b] <= busFP.mem_wd[8*b +: 8];
        end
    end

    always_comb begin
        busRR.mem_rd = '0;
        for (int b = 0; b < BS; b++)
            if (int'(busRR.mem_addr) + b < DEPTH) busRR.mem_rd[8*b +: 8] = memRR[int'(busRR.mem_addr) + b];
    end

    always_comb begin
        busFP.mem_rd = '0;
        for (int b = 0; b < BS; b++)
            if (int'(busFP.mem_addr) + b < DEPTH) busFP.mem_rd[8*b +: 8] = memFP[int'(busFP.mem_addr) + b];
    end

    // Write-strobe counters let the bench prove a write did or did not reach memory.
    always @(posedge clk) begin
        if (busRR.mem_we) weRR++;
        if (busFP.mem_we) weFP++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic compareAck(input string tag, input ackExp_t e, input logic iAck, input logic dAck,
                              input logic [31:0] iRdata, input logic iErr,
                              input logic [31:0] dRdata, input logic dErr);
        checkOutput({tag, "_ack_onehot"}, 32'(iAck & dAck), 32'd0);
        checkOutput({tag, "_ack_port"}, 32'(dAck), 32'(e.isD));
        checkOutput({tag, "_rdata"}, e.isD ? dRdata : iRdata, e.rdata);
        checkOutput({tag, "_err"}, 32'(e.isD ? dErr : iErr), 32'(e.err));
    endtask

    // Scoreboard monitors: each ack pops the oldest expected completion for that instance.
    always @(negedge clk) begin
        if (busRR.i_ack || busRR.d_ack) begin
            ackRR++;
            if (qRR.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rr_unexpected_ack: got i_ack=%b d_ack=%b, required no ack", busRR.i_ack, busRR.d_ack);
            end else begin
                compareAck("rr", qRR.pop_front(), busRR.i_ack, busRR.d_ack,
                           busRR.i_rdata, busRR.i_err, busRR.d_rdata, busRR.d_err);
            end
        end
    end

    always @(negedge clk) begin
        if (busFP.i_ack || busFP.d_ack) begin
            ackFP++;
            if (qFP.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL fp_unexpected_ack: got i_ack=%b d_ack=%b, required no ack", busFP.i_ack, busFP.d_ack);
            end else begin
                compareAck("fp", qFP.pop_front(), busFP.i_ack, busFP.d_ack,
                           busFP.i_rdata, busFP.i_err, busFP.d_rdata, busFP.d_err);
            end
        end
    end

    task automatic waitAcks(input bit fp, input int target, input string name);
        bit reached;
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            @(negedge clk);
            #1;
            reached = ((fp ? ackFP : ackRR) >= target);
        end
        checkOutput(name, 32'(reached), 32'd1);
    endtask

    // One isolated request on the round-robin instance, starting from IDLE.
    task automatic applyStimulus(input vec_t v, input int idx);
        int startAck;
        int startWe;
        int lat;
        bit seen;
        @(posedge clk);
        #1;
        startAck = ackRR;
        startWe  = weRR;
        qRR.push_back(ackExp_t'{v.isD, v.expRdata, v.expErr});
        if (v.isD) begin
            busRR.d_addr  = v.addr;
            busRR.d_we    = v.we;
            busRR.d_wdata = v.wdata;
            busRR.d_req   = 1'b1;
        end else begin
            busRR.i_addr = v.addr;
            busRR.i_req  = 1'b1;
        end
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            #1;
            lat++;
            seen = (ackRR != startAck);
        end
        checkOutput($sformatf("vec%0d_latency", idx), 32'(lat), 32'd3);
        busRR.i_req = 1'b0;
        busRR.d_req = 1'b0;
        @(negedge clk);
        #1;
        checkOutput($sformatf("vec%0d_ack_pulse", idx), 32'(busRR.i_ack | busRR.d_ack), 32'd0);
        checkOutput($sformatf("vec%0d_busy_idle", idx), 32'(busRR.busy), 32'd0);
        checkOutput($sformatf("vec%0d_write_count", idx), 32'(weRR - startWe),
                    (v.we && !v.expErr) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startAck;
        int startWe;
        total = 0;
        bad   = 0;
        ackRR = 0;
        ackFP = 0;
        weRR  = 0;
        weFP  = 0;

        //        isD   we    addr     wdata         expRdata      expErr
        vecs[0]  = '{1'b0, 1'b0, 12'h000, 32'h00000000, 32'h04030201, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 12'h004, 32'hAABBCCDD, 32'h0C0B0A09, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 12'h004, 32'h00000000, 32'hAABBCCDD, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'h004, 32'h00000000, 32'hAABBCCDD, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 12'h010, 32'h00000000, 32'h14131211, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'h011, 32'h00000000, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 12'h010, 32'h00000000, 32'h14131211, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 12'h011, 32'h11223344, 32'h14131211, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 12'h010, 32'h00000000, 32'h14131211, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 12'hFFF, 32'h00000000, 32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 12'hFFE, 32'h00000000, 32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 12'h000, 32'h5A5AA5A5, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 12'h000, 32'h00000000, 32'h5A5AA5A5, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 12'h001, 32'h00000000, 32'hDD5A5AA5, 1'b0};

        reset   = 1'b1;
        memLoad = 1'b1;
        busRR.i_req = 1'b0; busRR.i_addr = '0; busRR.d_req = 1'b0; busRR.d_we = 1'b0;
        busRR.d_addr = '0; busRR.d_wdata = '0;
        busFP.i_req = 1'b0; busFP.i_addr = '0; busFP.d_req = 1'b0; busFP.d_we = 1'b0;
        busFP.d_addr = '0; busFP.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        memLoad = 1'b0;

        checkOutput("reset_busy", 32'(busRR.busy), 32'd0);
        checkOutput("reset_i_ack", 32'(busRR.i_ack), 32'd0);
        checkOutput("reset_d_ack", 32'(busRR.d_ack), 32'd0);
        checkOutput("reset_i_err", 32'(busRR.i_err), 32'd0);
        checkOutput("reset_d_err", 32'(busRR.d_err), 32'd0);
        checkOutput("reset_i_rdata", busRR.i_rdata, 32'd0);
        checkOutput("reset_d_rdata", busRR.d_rdata, 32'd0);
        checkOutput("reset_mem_we", 32'(busRR.mem_we), 32'd0);
        checkOutput("reset_mem_addr", 32'(busRR.mem_addr), 32'd0);
        checkOutput("reset_fp_busy", 32'(busFP.busy), 32'd0);
        reset = 1'b0;

        // Round-robin: both held, D first after reset then strict alternation.
        @(posedge clk);
        #1;
        qRR.push_back(ackExp_t'{1'b1, 32'h0C0B0A09, 1'b0});
        qRR.push_back(ackExp_t'{1'b0, 32'h04030201, 1'b0});
        qRR.push_back(ackExp_t'{1'b1, 32'h0C0B0A09, 1'b0});
        qRR.push_back(ackExp_t'{1'b0, 32'h04030201, 1'b0});
        startAck = ackRR;
        busRR.i_addr = 12'h000; busRR.d_addr = 12'h008; busRR.d_we = 1'b0;
        busRR.i_req = 1'b1; busRR.d_req = 1'b1;
        waitAcks(1'b0, startAck + 4, "rr_alternate_done");
        busRR.i_req = 1'b0; busRR.d_req = 1'b0;
        @(negedge clk);
        #1;

        // Fixed priority: D starves I while held, I served once D drops.
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) qFP.push_back(ackExp_t'{1'b1, 32'h0C0B0A09, 1'b0});
        qFP.push_back(ackExp_t'{1'b0, 32'h04030201, 1'b0});
        startAck = ackFP;
        busFP.i_addr = 12'h000; busFP.d_addr = 12'h008; busFP.d_we = 1'b0;
        busFP.i_req = 1'b1; busFP.d_req = 1'b1;
        waitAcks(1'b1, startAck + 4, "fp_d_starves_i");
        busFP.d_req = 1'b0;
        waitAcks(1'b1, startAck + 5, "fp_i_after_d_drop");
        busFP.i_req = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);
        checkOutput("oor_write_mem16_19", {memRR[19], memRR[18], memRR[17], memRR[16]}, 32'h14131211);

        // Reset while a D write sits in ACCESS: no write, no ack, idle immediately.
        @(posedge clk);
        #1;
        startAck = ackRR;
        startWe  = weRR;
        busRR.d_addr = 12'h008; busRR.d_we = 1'b1; busRR.d_wdata = 32'hDEADBEEF; busRR.d_req = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_in_access_we", 32'(busRR.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busRR.busy), 32'd0);
        checkOutput("midrst_mem_we", 32'(busRR.mem_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        busRR.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_no_write", 32'(weRR - startWe), 32'd0);
        checkOutput("midrst_no_ack", 32'(ackRR - startAck), 32'd0);
        checkOutput("midrst_mem8_11", {memRR[11], memRR[10], memRR[9], memRR[8]}, 32'h0C0B0A09);
        checkOutput("midrst_i_rdata_cleared", busRR.i_rdata, 32'd0);

        checkOutput("rr_scoreboard_empty", 32'(qRR.size()), 32'd0);
        checkOutput("fp_scoreboard_empty", 32'(qFP.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
